// File: rtl/eightbit_bus_pkg.sv
// ============================================================================
// Module      : eightbit_bus_pkg
// Description : Shared types for the device bus controller: FSM state
//               encoding and the error codes reported on err_code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eightbit_bus_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_ACCESS = 2'd1,
    BUS_DONE   = 2'd2
  } bus_state_t;

  // Error codes held in err_code after a failed transfer.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DECODE  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } bus_err_t;

endpackage

`default_nettype wire

// File: rtl/device_bus_decode.sv
// ============================================================================
// Module      : device_bus_decode
// Description : Combinational address decoder. Takes the address bits above
//               the register window and reports whether the address falls in
//               the I/O region, which device window it selects, and whether
//               that window is populated.
// Ports       : addr_hi   in  AW-WB  address[AW-1:WINDOW_BITS]
//               is_io     out 1      address is inside the I/O region
//               idx       out DSW    device window index
//               idx_valid out 1      idx < DEVICE_COUNT
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module device_bus_decode #(
  parameter int                       ADDRESS_WIDTH       = 16,
  parameter int                       DEVICE_SELECT_WIDTH = 3,
  parameter int                       DEVICE_COUNT        = 8,
  parameter int                       WINDOW_BITS         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] DEVICE_BASE         = 16'hFF00
) (
  input  logic [ADDRESS_WIDTH-WINDOW_BITS-1:0] addr_hi,
  output logic                                 is_io,
  output logic [DEVICE_SELECT_WIDTH-1:0]       idx,
  output logic                                 idx_valid
);

  // One extra bit so that DEVICE_COUNT == 2**DSW is representable.
  localparam logic [DEVICE_SELECT_WIDTH:0] c_dev_count =
    (DEVICE_SELECT_WIDTH+1)'(DEVICE_COUNT);

  // The region tag is everything above the device index field; the low bits
  // of DEVICE_BASE are ignored so the region is always window-aligned.
  assign is_io = (addr_hi[ADDRESS_WIDTH-WINDOW_BITS-1:DEVICE_SELECT_WIDTH] ==
                  DEVICE_BASE[ADDRESS_WIDTH-1:WINDOW_BITS+DEVICE_SELECT_WIDTH]);

  assign idx       = addr_hi[DEVICE_SELECT_WIDTH-1:0];
  assign idx_valid = ({1'b0, idx} < c_dev_count);

endmodule

`default_nettype wire

// File: rtl/device_bus_ctrl.sv
// ============================================================================
// Module      : device_bus_ctrl
// Description : Address/device bus controller. Latches the address bus,
//               decodes it to RAM or one of 2**DEVICE_SELECT_WIDTH device
//               windows, drives registered one-hot strobes and completes each
//               transfer with a ready/done handshake. Unpopulated windows
//               raise a sticky decode error.
// Config      : DEVICE_BUS_TIMEOUT_EN - when defined, an ACCESS that sees no
//               ready for TIMEOUT_CYCLES+1 cycles is aborted with ERR_TIMEOUT.
//               When undefined, ACCESS waits on dev_ready indefinitely.
// Ports       : clk, rst (async, active-high)
//               address_in, address_read_enable, enable      - request side
//               address_out, mem_enable, dev_enable, dev_ready - target side
//               busy, done                                    - status
//               bus_error, err_code, err_addr, err_clear       - error report
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module device_bus_ctrl
  import eightbit_bus_pkg::*;
#(
  parameter int                       DATA_WIDTH          = 8,
  parameter int                       ADDRESS_WIDTH       = 16,
  parameter int                       DEVICE_SELECT_WIDTH = 3,
  parameter int                       DEVICE_COUNT        = 8,
  parameter int                       WINDOW_BITS         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] DEVICE_BASE         = 16'hFF00,
  parameter int                       TIMEOUT_CYCLES      = 15
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ADDRESS_WIDTH-1:0]              address_in,
  input  logic                                  address_read_enable,
  input  logic                                  enable,
  output logic [ADDRESS_WIDTH-1:0]              address_out,
  output logic                                  mem_enable,
  output logic [2**DEVICE_SELECT_WIDTH-1:0]     dev_enable,
  input  logic [2**DEVICE_SELECT_WIDTH-1:0]     dev_ready,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  bus_error,
  output logic [1:0]                            err_code,
  output logic [ADDRESS_WIDTH-1:0]              err_addr,
  input  logic                                  err_clear
);

  localparam int c_dev_n = 2**DEVICE_SELECT_WIDTH;

  // Reject parameter sets the decoder cannot represent.
  if (DEVICE_COUNT < 1 || DEVICE_COUNT > c_dev_n ||
      TIMEOUT_CYCLES < 1 || DATA_WIDTH < 1) begin : g_bad_config
    $error("device_bus_ctrl: invalid parameter set");
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  bus_state_t                 r_state;
  logic [ADDRESS_WIDTH-1:0]   r_addr_q;
  logic                       r_mem_enable;
  logic [c_dev_n-1:0]         r_dev_enable;
  logic                       r_bus_error;
  bus_err_t                   r_err_code;
  logic [ADDRESS_WIDTH-1:0]   r_err_addr;

  bus_state_t                 w_state_d;
  logic [ADDRESS_WIDTH-1:0]   w_addr_d;
  logic [ADDRESS_WIDTH-1:0]   w_eff_addr;
  logic                       w_mem_en_d;
  logic [c_dev_n-1:0]         w_dev_en_d;
  logic                       w_err_set;
  bus_err_t                   w_err_code_d;
  logic [ADDRESS_WIDTH-1:0]   w_err_addr_d;
  logic                       w_ready;

  logic                           w_is_io;
  logic [DEVICE_SELECT_WIDTH-1:0] w_idx;
  logic                           w_idx_valid;
  logic [c_dev_n-1:0]             w_dev_onehot;

`ifdef DEVICE_BUS_TIMEOUT_EN
  localparam int                   c_timer_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_timer_w-1:0] c_timeout = c_timer_w'(TIMEOUT_CYCLES);

  logic [c_timer_w-1:0] r_timer;
  logic [c_timer_w-1:0] w_timer_d;
`endif

  // An address presented together with enable is used directly, so a
  // latch-and-go request needs no extra cycle.
  assign w_eff_addr = address_read_enable ? address_in : r_addr_q;

  device_bus_decode #(
    .ADDRESS_WIDTH       (ADDRESS_WIDTH),
    .DEVICE_SELECT_WIDTH (DEVICE_SELECT_WIDTH),
    .DEVICE_COUNT        (DEVICE_COUNT),
    .WINDOW_BITS         (WINDOW_BITS),
    .DEVICE_BASE         (DEVICE_BASE)
  ) u_decode (
    .addr_hi   (w_eff_addr[ADDRESS_WIDTH-1:WINDOW_BITS]),
    .is_io     (w_is_io),
    .idx       (w_idx),
    .idx_valid (w_idx_valid)
  );

  assign w_dev_onehot = c_dev_n'(1) << w_idx;

  // Only one strobe is ever high, so the active target's ready can be
  // picked out by masking. RAM completes in its first ACCESS cycle.
  assign w_ready = r_mem_enable | (|(r_dev_enable & dev_ready));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BUS_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and next register values
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_d    = r_state;
    w_addr_d     = r_addr_q;
    w_mem_en_d   = r_mem_enable;
    w_dev_en_d   = r_dev_enable;
    w_err_set    = 1'b0;
    w_err_code_d = ERR_NONE;
    w_err_addr_d = r_err_addr;
`ifdef DEVICE_BUS_TIMEOUT_EN
    w_timer_d    = r_timer;
`endif

    case (r_state)
      BUS_IDLE: begin
        if (address_read_enable) begin
          w_addr_d = address_in;
        end
        if (enable) begin
`ifdef DEVICE_BUS_TIMEOUT_EN
          w_timer_d = '0;
`endif
          if (!w_is_io) begin
            w_mem_en_d = 1'b1;
            w_dev_en_d = '0;
            w_state_d  = BUS_ACCESS;
          end else if (w_idx_valid) begin
            w_mem_en_d = 1'b0;
            w_dev_en_d = w_dev_onehot;
            w_state_d  = BUS_ACCESS;
          end else begin
            // Unpopulated window: nothing to strobe, report and finish.
            w_mem_en_d   = 1'b0;
            w_dev_en_d   = '0;
            w_state_d    = BUS_DONE;
            w_err_set    = 1'b1;
            w_err_code_d = ERR_DECODE;
            w_err_addr_d = w_eff_addr;
          end
        end
      end

      BUS_ACCESS: begin
        if (w_ready) begin
          w_mem_en_d = 1'b0;
          w_dev_en_d = '0;
          w_state_d  = BUS_DONE;
        end
`ifdef DEVICE_BUS_TIMEOUT_EN
        else if (r_timer == c_timeout) begin
          w_mem_en_d   = 1'b0;
          w_dev_en_d   = '0;
          w_state_d    = BUS_DONE;
          w_err_set    = 1'b1;
          w_err_code_d = ERR_TIMEOUT;
          w_err_addr_d = r_addr_q;
        end else begin
          w_timer_d = r_timer + 1'b1;
        end
`endif
      end

      BUS_DONE: begin
        w_state_d = BUS_IDLE;
      end

      default: begin
        w_state_d  = BUS_IDLE;
        w_mem_en_d = 1'b0;
        w_dev_en_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address, strobe and error registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_q     <= '0;
      r_mem_enable <= 1'b0;
      r_dev_enable <= '0;
      r_bus_error  <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_err_addr   <= '0;
    end else begin
      r_addr_q     <= w_addr_d;
      r_mem_enable <= w_mem_en_d;
      r_dev_enable <= w_dev_en_d;
      // A new error takes priority over a simultaneous clear so it is
      // never lost.
      if (w_err_set) begin
        r_bus_error <= 1'b1;
        r_err_code  <= w_err_code_d;
        r_err_addr  <= w_err_addr_d;
      end else if (err_clear) begin
        r_bus_error <= 1'b0;
        r_err_code  <= ERR_NONE;
      end
    end
  end

`ifdef DEVICE_BUS_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else begin
      r_timer <= w_timer_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign address_out = r_addr_q;
  assign mem_enable  = r_mem_enable;
  assign dev_enable  = r_dev_enable;
  assign busy        = (r_state == BUS_ACCESS);
  assign done        = (r_state == BUS_DONE);
  assign bus_error   = r_bus_error;
  assign err_code    = r_err_code;
  assign err_addr    = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_device_bus_ctrl.sv
// ============================================================================
// Module      : tb_device_bus_ctrl
// Description : Scoreboard bench for device_bus_ctrl built with
//               DEVICE_COUNT=5. Stimulus pushes the expected outcome of each
//               transfer (and expected output snapshots) into queues; a
//               monitor on the falling edge compares them against the DUT.
//               Timeout expectations follow DEVICE_BUS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_device_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address_in;
  logic        address_read_enable;
  logic        enable;
  logic [15:0] address_out;
  logic        mem_enable;
  logic [7:0]  dev_enable;
  logic [7:0]  dev_ready;
  logic        busy;
  logic        done;
  logic        bus_error;
  logic [1:0]  err_code;
  logic [15:0] err_addr;
  logic        err_clear;

  always #5 clk = ~clk;

  device_bus_ctrl #(
    .DEVICE_COUNT (5)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .address_in          (address_in),
    .address_read_enable (address_read_enable),
    .enable              (enable),
    .address_out         (address_out),
    .mem_enable          (mem_enable),
    .dev_enable          (dev_enable),
    .dev_ready           (dev_ready),
    .busy                (busy),
    .done                (done),
    .bus_error           (bus_error),
    .err_code            (err_code),
    .err_addr            (err_addr),
    .err_clear           (err_clear)
  );

  // Expected result of one transfer, checked when done pulses.
  typedef struct {
    string       name;
    int          cycles;
    logic        mem;
    logic [7:0]  dev;
    logic        berr;
    logic [1:0]  code;
    logic [15:0] eaddr;
    logic [15:0] aout;
  } txn_t;

  // Expected value of every output at the next falling edge.
  typedef struct {
    string       name;
    logic [15:0] aout;
    logic        mem;
    logic [7:0]  dev;
    logic        busy;
    logic        done;
    logic        berr;
    logic [1:0]  code;
    logic [15:0] eaddr;
  } snap_t;

  txn_t  exp_q[$];
  snap_t snap_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt  = 0;
  int stall_seen = 0;
  bit end_req    = 1'b0;

  function automatic txn_t mk_txn(input string name, input int cycles, input logic mem,
                                  input logic [7:0] dev, input logic berr, input logic [1:0] code,
                                  input logic [15:0] eaddr, input logic [15:0] aout);
    txn_t t;
    t.name = name; t.cycles = cycles; t.mem = mem; t.dev = dev;
    t.berr = berr; t.code = code; t.eaddr = eaddr; t.aout = aout;
    return t;
  endfunction

  function automatic snap_t mk_snap(input string name, input logic [15:0] aout, input logic mem,
                                    input logic [7:0] dev, input logic bsy, input logic dn,
                                    input logic berr, input logic [1:0] code, input logic [15:0] eaddr);
    snap_t s;
    s.name = name; s.aout = aout; s.mem = mem; s.dev = dev; s.busy = bsy;
    s.done = dn; s.berr = berr; s.code = code; s.eaddr = eaddr;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  int         acc_cycles = 0;
  logic       seen_mem   = 1'b0;
  logic [7:0] seen_dev   = 8'h00;
  logic       prev_done  = 1'b0;

  always @(negedge clk) begin
    snap_t s;
    txn_t  t;
    while (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      check({s.name, ".address_out"}, 32'(address_out), 32'(s.aout));
      check({s.name, ".mem_enable"},  32'(mem_enable),  32'(s.mem));
      check({s.name, ".dev_enable"},  32'(dev_enable),  32'(s.dev));
      check({s.name, ".busy"},        32'(busy),        32'(s.busy));
      check({s.name, ".done"},        32'(done),        32'(s.done));
      check({s.name, ".bus_error"},   32'(bus_error),   32'(s.berr));
      check({s.name, ".err_code"},    32'(err_code),    32'(s.code));
      check({s.name, ".err_addr"},    32'(err_addr),    32'(s.eaddr));
    end

    if (rst) begin
      acc_cycles = 0;
      seen_mem   = 1'b0;
      seen_dev   = 8'h00;
      prev_done  = 1'b0;
    end else begin
      if (busy) begin
        acc_cycles++;
        seen_mem = seen_mem | mem_enable;
        seen_dev = seen_dev | dev_enable;
      end else begin
        check("strobes_low_outside_access", {23'd0, mem_enable, dev_enable}, 32'd0);
      end
      if (done) begin
        check("done_single_pulse", 32'(prev_done), 32'd0);
        check("done_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          t = exp_q.pop_front();
          check({t.name, ".access_cycles"}, 32'(acc_cycles), 32'(t.cycles));
          check({t.name, ".mem_strobe"},    32'(seen_mem),   32'(t.mem));
          check({t.name, ".dev_strobe"},    32'(seen_dev),   32'(t.dev));
          check({t.name, ".bus_error"},     32'(bus_error),  32'(t.berr));
          check({t.name, ".err_code"},      32'(err_code),   32'(t.code));
          check({t.name, ".err_addr"},      32'(err_addr),   32'(t.eaddr));
          check({t.name, ".address_out"},   32'(address_out), 32'(t.aout));
        end
        acc_cycles = 0;
        seen_mem   = 1'b0;
        seen_dev   = 8'h00;
      end
      prev_done = done;
    end

    check("wait_bound", 32'(stall_cnt), 32'(stall_seen));
    stall_seen = stall_cnt;

    if (end_req) begin
      check("pending_transfers", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic start(input logic [15:0] a, input bit bypass, input bit clr);
    @(posedge clk); #1;
    address_in          = a;
    address_read_enable = 1'b1;
    if (!bypass) begin
      @(posedge clk); #1;
      address_read_enable = 1'b0;
      address_in          = 16'hDEAD;
    end
    enable    = 1'b1;
    err_clear = clr;
    @(posedge clk); #1;
    enable              = 1'b0;
    address_read_enable = 1'b0;
    err_clear           = 1'b0;
  endtask

  // Raise the ready mask during the given ACCESS cycle (1-based).
  task automatic drive_ready(input int at, input logic [7:0] m);
    repeat (at - 1) begin
      @(posedge clk); #1;
    end
    dev_ready = m;
    @(posedge clk); #1;
    dev_ready = 8'h00;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) stall_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; address_in = 16'h0; address_read_enable = 1'b0; enable = 1'b0;
    dev_ready = 8'h00; err_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    snap_q.push_back(mk_snap("reset", 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0));
    @(posedge clk); #1;
    rst = 1'b0;

    // RAM access: single ACCESS cycle, no error.
    exp_q.push_back(mk_txn("ram_1234", 1, 1'b1, 8'h00, 1'b0, 2'd0, 16'h0000, 16'h1234));
    start(16'h1234, 1'b0, 1'b0);
    wait_done();

    // Device 2 stalls until the third ACCESS cycle.
    exp_q.push_back(mk_txn("dev2_ff25", 3, 1'b0, 8'b0000_0100, 1'b0, 2'd0, 16'h0000, 16'hFF25));
    start(16'hFF25, 1'b0, 1'b0);
    drive_ready(3, 8'b0000_0100);
    wait_done();

    // Device 1 never responds.
`ifdef DEVICE_BUS_TIMEOUT_EN
    exp_q.push_back(mk_txn("dev1_timeout", 16, 1'b0, 8'b0000_0010, 1'b1, 2'd2, 16'hFF10, 16'hFF10));
    start(16'hFF10, 1'b0, 1'b0);
    wait_done();
    pulse_clear();
    snap_q.push_back(mk_snap("timeout_cleared", 16'hFF10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 16'hFF10));
`else
    exp_q.push_back(mk_txn("dev1_slow", 20, 1'b0, 8'b0000_0010, 1'b0, 2'd0, 16'h0000, 16'hFF10));
    start(16'hFF10, 1'b0, 1'b0);
    drive_ready(20, 8'b0000_0010);
    wait_done();
    pulse_clear();
    snap_q.push_back(mk_snap("no_error_after_clear", 16'hFF10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000));
`endif

    // Unpopulated window 7: decode error, done right after enable.
    exp_q.push_back(mk_txn("decode_ff70", 0, 1'b0, 8'h00, 1'b1, 2'd1, 16'hFF70, 16'hFF70));
    start(16'hFF70, 1'b0, 1'b0);
    wait_done();
    pulse_clear();
    snap_q.push_back(mk_snap("decode_cleared", 16'hFF70, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 16'hFF70));

    // New decode error with err_clear in the same cycle: error must stick.
    exp_q.push_back(mk_txn("decode_ff60_vs_clear", 0, 1'b0, 8'h00, 1'b1, 2'd1, 16'hFF60, 16'hFF60));
    start(16'hFF60, 1'b1, 1'b1);
    wait_done();
    snap_q.push_back(mk_snap("error_kept", 16'hFF60, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd1, 16'hFF60));
    pulse_clear();
    snap_q.push_back(mk_snap("error_cleared", 16'hFF60, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 16'hFF60));

    // Latch-and-go on device 0; requests during ACCESS must be ignored.
    exp_q.push_back(mk_txn("bypass_ff00", 3, 1'b0, 8'b0000_0001, 1'b0, 2'd0, 16'hFF60, 16'hFF00));
    start(16'hFF00, 1'b1, 1'b0);
    enable = 1'b1; address_read_enable = 1'b1; address_in = 16'h1234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b0; address_read_enable = 1'b0;
    dev_ready = 8'b0000_0001;
    @(posedge clk); #1;
    dev_ready = 8'h00;
    wait_done();

    // Reset in the middle of an access on device 3.
    start(16'hFF30, 1'b0, 1'b0);
    snap_q.push_back(mk_snap("dev3_in_access", 16'hFF30, 1'b0, 8'b0000_1000, 1'b1, 1'b0, 1'b0, 2'd0, 16'hFF60));
    @(posedge clk); #2;
    rst = 1'b1;
    snap_q.push_back(mk_snap("async_reset_mid_access", 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0));
    @(posedge clk); #1;
    snap_q.push_back(mk_snap("held_in_reset", 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    snap_q.push_back(mk_snap("idle_after_reset", 16'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0));
    @(posedge clk); #1;
    end_req = 1'b1;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

endmodule

`default_nettype wire
